multicycle_controller: RTL and testbench

Control FSM that sequences a shared-ALU, shared-memory multi-cycle RV32 datapath (fetch, decode, execute, memory, writeback), replacing per-instruction combinational control. Sits beside the datapath and drives its mux selects and write enables from the IR opcode, the ALU zero flag and a memory-ready handshake. Base ISA: lw, sw, R-type, beq.

---
 rtl/multicycle_controller_pkg.sv | 47 ++++
 rtl/multicycle_controller_imm_src_decoder.sv | 18 +
 rtl/multicycle_controller.sv | 158 +++++++++++++++
 tb/tb_multicycle_controller.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32 control FSM: opcodes, state codes and datapath select values.
// The RV_EXT_OPS_EN macro (in the top) enables the EXECUTEI and JAL states listed here.
package multicycle_controller_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_BEQ      = 4'd8,
    S_EXECUTEI = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;

  localparam logic [1:0] B_RS2   = 2'b00;
  localparam logic [1:0] B_IMM   = 2'b01;
  localparam logic [1:0] B_FOUR  = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_imm_src_decoder.sv
// Opcode -> immediate format select; purely combinational so the single-cycle core can share it.
module imm_src_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  always_comb begin
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for a shared-ALU, shared-memory multi-cycle RV32 datapath (lw, sw, R-type, beq).
// Define RV_EXT_OPS_EN to add the I-type ALU (EXECUTEI) and JAL sequences.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               reg_write,
  output logic [1:0]         imm_src,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_t     state_q, state_d;
  logic [1:0] imm_dec;

  imm_src_decoder u_imm_src_decoder (
    .op      (op),
    .imm_src (imm_dec)
  );

  // NOTE: state is the only storage; non-blocking here, blocking in the combinational decode below.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Outputs depend on mem_ready/zero in the same cycle and must drop the instant reset asserts,
  // so they are decoded combinationally from the state register.
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    state_d    = S_FETCH;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = A_PC;
    alu_src_b  = B_RS2;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    imm_src    = imm_dec;

    case (state_q)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = B_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        state_d    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_BEQ:       state_d = S_BEQ;
`ifdef RV_EXT_OPS_EN
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
`endif
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
        state_d  = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        alu_src_a = A_RS1;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = A_RS1;
        alu_op    = ALU_SUB;
        pc_write  = zero;
      end
`ifdef RV_EXT_OPS_EN
      S_EXECUTEI: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_JAL: begin
        // PC+4 from OldPC goes to ALUOut for the link while PC takes the target already in ALUOut.
        alu_src_a = A_OLDPC;
        alu_src_b = B_FOUR;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
`endif
      default: begin
        // Unreachable codes look like FETCH with no requests and recover on the next edge.
        alu_src_b  = B_FOUR;
        result_src = RES_ALU;
      end
    endcase

    if (!rst) begin
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      reg_write  = 1'b0;
      imm_src    = 2'b00;
      illegal    = 1'b0;
    end
  end

  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: each instruction expands into an expected per-cycle trace that is
// compared against the DUT every cycle; honours RV_EXT_OPS_EN like the design.
module tb_multicycle_controller;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] BQ = 7'b1100011, IT = 7'b0010011, JL = 7'b1101111, BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic       zero, mem_ready;
  logic       pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [6:0]  op;
    logic        z;
    logic        mr;
    logic [20:0] e;
  } cyc_t;

  cyc_t       q[$];
  logic [6:0] cur_op;
  logic       cur_z;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .imm_src(imm_src), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // Field order: state, pc_write, adr_src, mem_read, mem_write, ir_write, result_src,
  // alu_src_a, alu_src_b, alu_op, reg_write, imm_src, illegal.
  function automatic logic [20:0] dut_vec();
    return {state, pc_write, adr_src, mem_read, mem_write, ir_write, result_src,
            alu_src_a, alu_src_b, alu_op, reg_write, imm_src, illegal};
  endfunction

  function automatic logic [1:0] imm_of(logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // One expected cycle: pcw adr mrd mwr irw rs a b alu rw ill, plus the mem_ready driven that cycle.
  task automatic push(int st, bit pcw, bit adr, bit mrd, bit mwr, bit irw, logic [1:0] rs,
                      logic [1:0] a, logic [1:0] b, logic [1:0] alu, bit rw, bit ill, bit mr_in);
    cyc_t c;
    c.op = cur_op;
    c.z  = cur_z;
    c.mr = mr_in;
    c.e  = {4'(st), pcw, adr, mrd, mwr, irw, rs, a, b, alu, rw, imm_of(cur_op), ill};
    q.push_back(c);
  endtask

  // Expand one instruction into its cycle trace; lat is the hand-computed instruction length.
  task automatic instr(logic [6:0] o, int fw, int mw, bit z, int lat);
    int n0;
    bit ext;
`ifdef RV_EXT_OPS_EN
    ext = 1'b1;
`else
    ext = 1'b0;
`endif
    cur_op = o;
    cur_z  = z;
    n0 = q.size();
    repeat (fw) push(0, 0,0,1,0,0, 2'b10,2'b00,2'b10,2'b00, 0,0, 0);
    push(0, 1,0,1,0,1, 2'b10,2'b00,2'b10,2'b00, 0,0, 1);
    if (o == LW || o == SW) begin
      push(1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 0,0, 0);
      push(2, 0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 0,0, 1);
      if (o == LW) begin
        repeat (mw) push(3, 0,1,1,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0, 0);
        push(3, 0,1,1,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0, 1);
        push(4, 0,0,0,0,0, 2'b01,2'b00,2'b00,2'b00, 1,0, 0);
      end else begin
        repeat (mw) push(5, 0,1,0,1,0, 2'b00,2'b00,2'b00,2'b00, 0,0, 0);
        push(5, 0,1,0,1,0, 2'b00,2'b00,2'b00,2'b00, 0,0, 1);
      end
    end else if (o == RT) begin
      push(1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 0,0, 1);
      push(6, 0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0,0, 1);
      push(7, 0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,0, 0);
    end else if (o == BQ) begin
      push(1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 0,0, 1);
      push(8, z,0,0,0,0, 2'b00,2'b10,2'b00,2'b01, 0,0, 0);
    end else if (ext && o == IT) begin
      push(1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 0,0, 1);
      push(9, 0,0,0,0,0, 2'b00,2'b10,2'b01,2'b10, 0,0, 1);
      push(7, 0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,0, 1);
    end else if (ext && o == JL) begin
      push(1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 0,0, 1);
      push(10, 1,0,0,0,0, 2'b00,2'b01,2'b10,2'b00, 0,0, 1);
      push(7, 0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,0, 1);
    end else begin
      push(1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 0,1, 1);
    end
    check($sformatf("latency_op%b", o), 32'(q.size() - n0), 32'(lat));
  endtask

  // Drive each queued cycle just after the rising edge and compare on the falling edge.
  task automatic run(int n);
    cyc_t c;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      c = q.pop_front();
      op = c.op;
      zero = c.z;
      mem_ready = c.mr;
      @(negedge clk);
      check($sformatf("cycle_op%b_st%0d", c.op, c.e[20:17]), 32'(dut_vec()), 32'(c.e));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int ext_lat;
`ifdef RV_EXT_OPS_EN
    ext_lat = 4;
`else
    ext_lat = 2;
`endif
    rst = 1'b0; op = LW; zero = 1'b0; mem_ready = 1'b1;
    #2;
    check("reset_outputs", 32'(dut_vec()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    instr(LW, 0, 0, 1'b1, 5);      run(1000);
    instr(RT, 3, 0, 1'b0, 7);      run(1000);
    instr(BQ, 0, 0, 1'b1, 3);      run(1000);
    instr(BQ, 0, 0, 1'b0, 3);      run(1000);
    instr(BAD, 0, 0, 1'b0, 2);     run(1000);
    instr(SW, 0, 2, 1'b1, 6);      run(1000);
    instr(LW, 1, 1, 1'b0, 7);      run(1000);
    instr(IT, 0, 0, 1'b0, ext_lat); run(1000);
    instr(JL, 0, 0, 1'b0, ext_lat); run(1000);

    // Reset asserted while a store is stalled in MEMWRITE.
    instr(SW, 0, 5, 1'b0, 9);
    run(4);
    q.delete();
    #2;
    check("sw_stalled_mem_write", 32'(mem_write), 32'd1);
    check("sw_stalled_state", 32'(state), 32'd5);
    rst = 1'b0;
    #1;
    check("mid_reset_mem_write", 32'(mem_write), 32'd0);
    check("mid_reset_outputs", 32'(dut_vec()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; op = LW; mem_ready = 1'b0;
    @(negedge clk);
    check("post_reset_state", 32'(state), 32'd0);
    check("post_reset_mem_read", 32'(mem_read), 32'd1);
    @(posedge clk); #1;

    instr(RT, 0, 0, 1'b1, 4);      run(1000);
    instr(LW, 0, 0, 1'b0, 5);      run(1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
